// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// The requester enum doubles as the encoding of the round-robin pointer.
package rf_arb_pkg;

  typedef enum logic {
    REQ_WB  = 1'b0,
    REQ_MDU = 1'b1
  } req_e;

  localparam int         NUM_REGS = 32;
  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Valid/ready write-request bundle for the two register-file writers (WB and MDU).
// The master drives requests and the arbiter (slave) answers with ready.
interface rf_wb_arbiter_if #(
  parameter int REG_WIDTH = 32
);

  logic                 wb_valid;
  logic                 wb_ready;
  logic [4:0]           wb_rd;
  logic [REG_WIDTH-1:0] wb_data;

  logic                 mdu_valid;
  logic                 mdu_ready;
  logic [4:0]           mdu_rd;
  logic [REG_WIDTH-1:0] mdu_data;

  modport master (
    output wb_valid, wb_rd, wb_data,
    output mdu_valid, mdu_rd, mdu_data,
    input  wb_ready, mdu_ready
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    input  mdu_valid, mdu_rd, mdu_data,
    output wb_ready, mdu_ready
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy flags for registers still waiting on an MDU result, plus the hazard query.
// A set and a clear of the same register in one cycle leaves it busy.
module rf_scoreboard
  import rf_arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [4:0]          set_rd,
  input  logic                clr_en,
  input  logic [4:0]          clr_rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                rs1_busy,
  output logic                rs2_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // x0 is never marked, so bit 0 stays clear without extra masking.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && set_rd != ZERO_REG) set_mask[set_rd] = 1'b1;
    if (clr_en) clr_mask[clr_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= (busy_q & ~clr_mask) | set_mask;
  end

  assign busy_vec = busy_q;

  // The result being written this cycle is forwarded by the register file.
  assign rs1_busy = busy_q[rs1] && (rs1 != ZERO_REG) && !(clr_en && clr_rd == rs1);
  assign rs2_busy = busy_q[rs2] && (rs2 != ZERO_REG) && !(clr_en && clr_rd == rs2);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between WB and the MDU.
// Define RF_ARB_STATS_EN to build the saturating conflict/stall counters.
module rf_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  rf_wb_arbiter_if.slave       req,
  input  logic                 mdu_issue,
  input  logic [4:0]           mdu_issue_rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [REG_WIDTH-1:0] rf_din,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic [CNT_WIDTH-1:0] conflict_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  req_e last_grant;
  logic wb_real;
  logic mdu_real;
  logic grant_wb;
  logic grant_mdu;

  assign wb_real  = req.wb_valid  && (req.wb_rd  != ZERO_REG);
  assign mdu_real = req.mdu_valid && (req.mdu_rd != ZERO_REG);

  // Ready ignores the writer's own valid; x0 writes are always accepted and dropped.
  assign req.wb_ready  = !reset && ((req.wb_rd == ZERO_REG) || !mdu_real || (last_grant == REQ_MDU));
  assign req.mdu_ready = !reset && ((req.mdu_rd == ZERO_REG) || !wb_real || (last_grant == REQ_WB));

  assign grant_wb  = wb_real  && req.wb_ready;
  assign grant_mdu = mdu_real && req.mdu_ready;

  always_comb begin
    rf_we  = grant_wb || grant_mdu;
    rf_rd  = ZERO_REG;
    rf_din = '0;
    if (grant_mdu) begin
      rf_rd  = req.mdu_rd;
      rf_din = req.mdu_data;
    end else if (grant_wb) begin
      rf_rd  = req.wb_rd;
      rf_din = req.wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          last_grant <= REQ_MDU;
    else if (grant_wb)  last_grant <= REQ_WB;
    else if (grant_mdu) last_grant <= REQ_MDU;
  end

  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (mdu_issue),
    .set_rd   (mdu_issue_rd),
    .clr_en   (grant_mdu),
    .clr_rd   (req.mdu_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .busy_vec (busy_vec),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

`ifdef RF_ARB_STATS_EN
  logic                 conflict;
  logic                 stall;
  logic [CNT_WIDTH-1:0] conflict_q;
  logic [CNT_WIDTH-1:0] stall_q;

  assign conflict = wb_real && mdu_real;
  assign stall    = (wb_real && !req.wb_ready) || (mdu_real && !req.mdu_ready);

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_q <= '0;
      stall_q    <= '0;
    end else begin
      if (conflict && conflict_q != '1) conflict_q <= conflict_q + CNT_WIDTH'(1);
      if (stall && stall_q != '1)       stall_q    <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign conflict_cnt = conflict_q;
  assign stall_cnt    = stall_q;
`else
  assign conflict_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule
